condicionador_botoes: RTL and testbench
=======================================

# condicionador_botoes

Input conditioner for the eight raw puzzle buttons, on the input side of the `botoes` interface. It synchronizes each raw pin into the `clock` domain and debounces each pin independently. It presents clean held levels plus one-cycle press pulses to the game datapath. A priority-encoded code of the lowest pressed button is provided for the control unit and debug displays.

## Interface
- `DEBOUNCE`, 50000 — consecutive cycles a synchronized input must differ from its stable value before the stable value changes; ≥1 (1 ms at 50 MHz).
- `REPEAT_DELAY`, 25000000 — cycles of unchanged held `botoes` before the first auto-repeat pulse; ≥1; used only with `CONDICIONADOR_REPEAT_EN`.
- `REPEAT_RATE`, 5000000 — cycles between later auto-repeat pulses; ≥1; used only with `CONDICIONADOR_REPEAT_EN`.
- `clock` in 1 — single system clock, rising edge.
- `reset` in 1 — asynchronous, active-low.
- `botoes_raw` in 8 — raw, asynchronous, bouncing button pins, active-high.
- `botoes` out 8 — debounced stable levels.
- `pulsos` out 8 — one-cycle pulse per button on stable 0→1 (and on auto-repeat).
- `algum_botao` out 1 — OR of `botoes`.
- `codigo` out 3 — index of the lowest set bit of `botoes`; 0 when none set.
- `db_estado` out 8 — per-bit flag, high while that button's debounce counter is nonzero.

## Operation
- Per bit i, two-flop synchronizer: `raw → s1[i] → s2[i]`.
- Per bit i, counter `cnt[i]`, width clog2(DEBOUNCE+1):
  - if `s2[i] == botoes[i]`: `cnt[i] <= 0`
  - else if `cnt[i] == DEBOUNCE-1`: `botoes[i] <= s2[i]`, `cnt[i] <= 0`
  - else: `cnt[i] <= cnt[i]+1`
- Any glitch shorter than DEBOUNCE synchronized cycles clears `cnt[i]` and leaves `botoes[i]` unchanged.
- Per-bit states, implicit in (`botoes[i]`, `cnt[i]≠0`): SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTA. Transitions follow the counter rule above.
- `pulsos[i]` is registered and high for exactly the cycle after the edge where `botoes[i]` goes 0→1. The 1→0 transition produces no pulse.
- Bits are fully independent. Simultaneous confirmations on several bits assert several `pulsos` bits in the same cycle.
- `algum_botao`, `codigo` and `db_estado` are combinational from registers. `codigo` priority: bit 0 highest.

## Timing
- Reset (`reset`=0), asynchronous: `s1`, `s2`, `cnt`, `botoes`, `pulsos` go to 0. Therefore `algum_botao`=0, `codigo`=0, `db_estado`=0.
- Reset released with a pin already held: that pin is treated as a new press, giving a pulse after the full latency.
- Reset mid-count discards the partial count.
- Latency: raw change sampled at edge k → `s2` at edge k+2 → `botoes` at edge k+1+DEBOUNCE+1 = k+DEBOUNCE+2.
- `pulsos` is high during the cycle following that edge, for 1 cycle.
- Counter never wraps. The terminal compare at DEBOUNCE-1 always clears it.
- DEBOUNCE=1: stable follows `s2` with 1 cycle extra delay.

## Configuration
- `CONDICIONADOR_REPEAT_EN` defined: adds one shared repeat counter (width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)).
  - While `botoes`≠0 and unchanged from the previous cycle, the counter counts.
  - At REPEAT_DELAY cycles it asserts `pulsos <= botoes` for one cycle and reloads for REPEAT_RATE. Each later REPEAT_RATE expiry repeats this.
  - Any change of `botoes`, or `botoes`=0, clears the counter and returns to the delay phase.
  - A repeat pulse coinciding with a new 0→1 press is ORed with the press pulse, never duplicated.
- Undefined: no repeat logic; `pulsos` carries only press edges; REPEAT_* are ignored.

## Test plan
- DEBOUNCE=4; reset low then high; `botoes_raw`=0 → all outputs 0 throughout.
- `botoes_raw[3]` 0→1 held → `botoes`=8'h08 at 6 cycles after first sample; `pulsos`=8'h08 for exactly 1 cycle; `codigo`=3, `algum_botao`=1.
- `botoes_raw[0]` bounces 1,0,1,0 every 2 cycles, then settles at 1 → no change during bounce; `botoes[0]` rises 6 cycles after settling; a single pulse.
- Bits 2 and 5 rise on the same cycle → `pulsos`=8'h24 in one cycle; `codigo`=2; release bit 2 → `codigo`=5, no pulse.
- Reset asserted while `cnt[1]`=2 → all outputs 0 immediately; after release with bit 1 still held, full 6-cycle latency then pulse.
- With `CONDICIONADOR_REPEAT_EN`, REPEAT_DELAY=10, REPEAT_RATE=3, bit 4 held → pulses 10, 13, 16… cycles after the press pulse; releasing bit 4 stops them.

Source files
------------

// File: rtl/condicionador_botoes_if.sv
// Button conditioner port bundle: raw pins in, debounced levels, pulses and status out.
// slave is the conditioner side, master is the board/datapath side.
interface condicionador_botoes_if;

    logic [7:0] botoes_raw;
    logic [7:0] botoes;
    logic [7:0] pulsos;
    logic       algum_botao;
    logic [2:0] codigo;
    logic [7:0] db_estado;

    modport slave (
        input  botoes_raw,
        output botoes,
        output pulsos,
        output algum_botao,
        output codigo,
        output db_estado
    );

    modport master (
        output botoes_raw,
        input  botoes,
        input  pulsos,
        input  algum_botao,
        input  codigo,
        input  db_estado
    );

endinterface

// File: rtl/condicionador_botoes.sv
// Synchronizes and debounces eight raw buttons, producing stable levels, press pulses and status.
// Optional auto-repeat of held buttons is enabled by defining CONDICIONADOR_REPEAT_EN.
module condicionador_botoes #(
    parameter int unsigned DEBOUNCE     = 50000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic                 clock,
    input  logic                 reset,
    condicionador_botoes_if.slave bus
);

    localparam int unsigned N_BOTOES = 8;
    localparam int unsigned CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE - 1);

    // Zero-valued timing parameters would make the terminal compares unreachable.
    if (DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_invalido
        $error("condicionador_botoes: DEBOUNCE, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [N_BOTOES-1:0] s1;
    logic [N_BOTOES-1:0] s2;
    logic [N_BOTOES-1:0] estavel;
    logic [N_BOTOES-1:0] estavel_prox;
    logic [N_BOTOES-1:0] pulso;
    logic [N_BOTOES-1:0] pulso_prox;
    logic [N_BOTOES-1:0] ativo;
    logic [2:0]          codigo_c;
    logic [CW-1:0]       cnt      [N_BOTOES];
    logic [CW-1:0]       cnt_prox [N_BOTOES];

    // Two-flop synchronizer per pin.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.botoes_raw;
            s2 <= s1;
        end
    end

    // Per-bit debounce: any agreement with the stable level restarts the count.
    always_comb begin
        for (int i = 0; i < N_BOTOES; i++) begin
            estavel_prox[i] = estavel[i];
            cnt_prox[i]     = '0;
            if (s2[i] == estavel[i]) begin
                cnt_prox[i] = '0;
            end else if (cnt[i] == CNT_FIM) begin
                estavel_prox[i] = s2[i];
                cnt_prox[i]     = '0;
            end else begin
                cnt_prox[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estavel <= '0;
            for (int i = 0; i < N_BOTOES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            estavel <= estavel_prox;
            for (int i = 0; i < N_BOTOES; i++) begin
                cnt[i] <= cnt_prox[i];
            end
        end
    end

`ifdef CONDICIONADOR_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] FIM_ATRASO = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] FIM_TAXA   = RW'(REPEAT_RATE - 1);

    logic [RW-1:0]       rcnt;
    logic [RW-1:0]       rcnt_prox;
    logic                fase_taxa;
    logic                fase_taxa_prox;
    logic [N_BOTOES-1:0] repete;

    // Shared repeat timer: delay phase first, then rate phase while the held set is constant.
    always_comb begin
        rcnt_prox      = rcnt + RW'(1);
        fase_taxa_prox = fase_taxa;
        repete         = '0;
        if ((estavel_prox != estavel) || (estavel == '0)) begin
            rcnt_prox      = '0;
            fase_taxa_prox = 1'b0;
        end else if (rcnt == (fase_taxa ? FIM_TAXA : FIM_ATRASO)) begin
            rcnt_prox      = '0;
            fase_taxa_prox = 1'b1;
            repete         = estavel;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rcnt      <= '0;
            fase_taxa <= 1'b0;
        end else begin
            rcnt      <= rcnt_prox;
            fase_taxa <= fase_taxa_prox;
        end
    end

    assign pulso_prox = (estavel_prox & ~estavel) | repete;
`else
    assign pulso_prox = estavel_prox & ~estavel;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pulso <= '0;
        end else begin
            pulso <= pulso_prox;
        end
    end

    // Lowest pressed button wins; scan from the top so bit 0 overrides.
    always_comb begin
        codigo_c = 3'd0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (estavel[i]) begin
                codigo_c = 3'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_BOTOES; i++) begin
            ativo[i] = (cnt[i] != '0);
        end
    end

    assign bus.botoes      = estavel;
    assign bus.pulsos      = pulso;
    assign bus.algum_botao = |estavel;
    assign bus.codigo      = codigo_c;
    assign bus.db_estado   = ativo;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes with DEBOUNCE=4; pulses are checked against a scoreboard.
// Define CONDICIONADOR_REPEAT_EN to also exercise auto-repeat (REPEAT_DELAY=10, REPEAT_RATE=3).
module tb_condicionador_botoes;

    logic clock;
    logic reset;
    int   cyc;
    int   n_pass;
    int   n_total;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } esperado_t;

    esperado_t sb [$];

    condicionador_botoes_if bus ();

    condicionador_botoes #(
        .DEBOUNCE    (4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: every nonzero pulsos cycle must match the front of the scoreboard.
    always @(negedge clock) begin
        esperado_t e;
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            n_total++;
            $display("FAIL pulse_missed: expected %h at cycle %0d, got 00 (now %0d)", sb[0].val, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (bus.pulsos !== 8'h00) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL pulse_unexpected: got %h at cycle %0d, required none", bus.pulsos, cyc);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.val !== bus.pulsos) begin
                    $display("FAIL pulse_value: got %h at cycle %0d, required %h at cycle %0d", bus.pulsos, cyc, e.val, e.cyc);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.botoes_raw = 8'h00;
        tick(3);
        n_total++;
        if ({bus.botoes, bus.pulsos, bus.algum_botao, bus.codigo, bus.db_estado} !== 28'h0) begin
            $display("FAIL reset_outputs: got botoes=%h pulsos=%h algum=%b codigo=%0d db=%h, required all 0",
                     bus.botoes, bus.pulsos, bus.algum_botao, bus.codigo, bus.db_estado);
        end else n_pass++;
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            n_total++;
            if ({bus.botoes, bus.pulsos, bus.algum_botao, bus.codigo, bus.db_estado} !== 28'h0) begin
                $display("FAIL idle_outputs: cycle %0d got botoes=%h pulsos=%h algum=%b codigo=%0d db=%h, required all 0",
                         cyc, bus.botoes, bus.pulsos, bus.algum_botao, bus.codigo, bus.db_estado);
            end else n_pass++;
        end
    endtask

    task automatic test_single_press();
        int n;
        n = cyc;
        bus.botoes_raw = 8'h08;
        sb.push_back('{n + 6, 8'h08});
        tick(3);
        n_total++;
        if (bus.db_estado !== 8'h08) $display("FAIL single_db_estado: got %h, required 08", bus.db_estado);
        else n_pass++;
        tick(2);
        n_total++;
        if (bus.botoes !== 8'h00) $display("FAIL single_early: got botoes=%h at +5, required 00", bus.botoes);
        else n_pass++;
        tick(1);
        n_total++;
        if (bus.botoes !== 8'h08 || bus.codigo !== 3'd3 || bus.algum_botao !== 1'b1 || bus.db_estado !== 8'h00)
            $display("FAIL single_level: got botoes=%h codigo=%0d algum=%b db=%h, required 08/3/1/00",
                     bus.botoes, bus.codigo, bus.algum_botao, bus.db_estado);
        else n_pass++;
        tick(1);
        bus.botoes_raw = 8'h00;
        tick(8);
        n_total++;
        if (bus.botoes !== 8'h00 || bus.algum_botao !== 1'b0 || bus.codigo !== 3'd0)
            $display("FAIL single_release: got botoes=%h algum=%b codigo=%0d, required 00/0/0",
                     bus.botoes, bus.algum_botao, bus.codigo);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [7:0] padrao;
        int m;
        padrao = 8'h00;
        for (int k = 0; k < 4; k++) begin
            padrao = (k % 2 == 0) ? 8'h01 : 8'h00;
            bus.botoes_raw = padrao;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                n_total++;
                if (bus.botoes !== 8'h00) $display("FAIL bounce_stable: got botoes=%h during bounce, required 00", bus.botoes);
                else n_pass++;
            end
        end
        m = cyc;
        bus.botoes_raw = 8'h01;
        sb.push_back('{m + 6, 8'h01});
        tick(5);
        n_total++;
        if (bus.botoes !== 8'h00) $display("FAIL bounce_early: got botoes=%h at +5, required 00", bus.botoes);
        else n_pass++;
        tick(1);
        n_total++;
        if (bus.botoes !== 8'h01 || bus.codigo !== 3'd0 || bus.algum_botao !== 1'b1)
            $display("FAIL bounce_level: got botoes=%h codigo=%0d algum=%b, required 01/0/1",
                     bus.botoes, bus.codigo, bus.algum_botao);
        else n_pass++;
        tick(1);
        bus.botoes_raw = 8'h00;
        tick(8);
    endtask

    task automatic test_simultaneous();
        int n;
        n = cyc;
        bus.botoes_raw = 8'h24;
        sb.push_back('{n + 6, 8'h24});
        tick(6);
        n_total++;
        if (bus.botoes !== 8'h24 || bus.codigo !== 3'd2)
            $display("FAIL simul_level: got botoes=%h codigo=%0d, required 24/2", bus.botoes, bus.codigo);
        else n_pass++;
        tick(1);
        bus.botoes_raw = 8'h20;
        tick(6);
        n_total++;
        if (bus.botoes !== 8'h20 || bus.codigo !== 3'd5 || bus.algum_botao !== 1'b1)
            $display("FAIL simul_release2: got botoes=%h codigo=%0d algum=%b, required 20/5/1",
                     bus.botoes, bus.codigo, bus.algum_botao);
        else n_pass++;
        tick(1);
        bus.botoes_raw = 8'h00;
        tick(8);
    endtask

    task automatic test_reset_mid_count();
        int r;
        bus.botoes_raw = 8'h02;
        tick(4);
        n_total++;
        if (bus.db_estado !== 8'h02 || bus.botoes !== 8'h00)
            $display("FAIL midcount_pre: got db=%h botoes=%h, required 02/00", bus.db_estado, bus.botoes);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if ({bus.botoes, bus.pulsos, bus.algum_botao, bus.codigo, bus.db_estado} !== 28'h0)
            $display("FAIL midcount_reset: got botoes=%h pulsos=%h algum=%b codigo=%0d db=%h, required all 0",
                     bus.botoes, bus.pulsos, bus.algum_botao, bus.codigo, bus.db_estado);
        else n_pass++;
        tick(2);
        r = cyc;
        reset = 1'b1;
        sb.push_back('{r + 6, 8'h02});
        tick(5);
        n_total++;
        if (bus.botoes !== 8'h00) $display("FAIL midcount_early: got botoes=%h at +5, required 00", bus.botoes);
        else n_pass++;
        tick(1);
        n_total++;
        if (bus.botoes !== 8'h02 || bus.codigo !== 3'd1)
            $display("FAIL midcount_level: got botoes=%h codigo=%0d, required 02/1", bus.botoes, bus.codigo);
        else n_pass++;
        tick(1);
        bus.botoes_raw = 8'h00;
        tick(8);
    endtask

`ifdef CONDICIONADOR_REPEAT_EN
    task automatic test_repeat();
        int n;
        n = cyc;
        bus.botoes_raw = 8'h10;
        sb.push_back('{n + 6,  8'h10});
        sb.push_back('{n + 16, 8'h10});
        sb.push_back('{n + 19, 8'h10});
        sb.push_back('{n + 22, 8'h10});
        sb.push_back('{n + 25, 8'h10});
        tick(22);
        bus.botoes_raw = 8'h00;
        tick(6);
        n_total++;
        if (bus.botoes !== 8'h00) $display("FAIL repeat_release: got botoes=%h, required 00", bus.botoes);
        else n_pass++;
        tick(12);
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        bus.botoes_raw = 8'h00;
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
`ifdef CONDICIONADOR_REPEAT_EN
        test_repeat();
`endif
        tick(4);
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d pulses still pending, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
